// File: rtl/sd_fifo_bx_if.sv
// sd_fifo_bx_if: producer/consumer handshake bundle for sd_fifo_bx.
// Valid/ready rule for both sides: a beat moves on a rising clk edge
// exactly when srdy and drdy are both high. srdy and its data are held
// until that edge. drdy never depends on srdy within the same cycle.
// commit/abort are sampled on every edge, whether or not a beat moves.
interface sd_fifo_bx_if #(
  parameter int width = 8,
  parameter int depth = 16
);
  localparam int asz = $clog2(depth);

  logic             c_srdy;
  logic             c_drdy;
  logic             c_commit;
  logic             c_abort;
  logic [width-1:0] c_data;
  logic             p_srdy;
  logic             p_drdy;
  logic             p_commit;
  logic             p_abort;
  logic [width-1:0] p_data;
  logic [asz:0]     c_usage;
  logic [asz:0]     p_usage;
  logic             c_afull;

  // FIFO side
  modport slave (
    input  c_srdy, c_commit, c_abort, c_data,
    input  p_drdy, p_commit, p_abort,
    output c_drdy, p_srdy, p_data, c_usage, p_usage, c_afull
  );

  // producer/consumer side
  modport master (
    output c_srdy, c_commit, c_abort, c_data,
    output p_drdy, p_commit, p_abort,
    input  c_drdy, p_srdy, p_data, c_usage, p_usage, c_afull
  );
endinterface

// File: rtl/sd_fifo_bx.sv
// sd_fifo_bx: transactional srdy/drdy FIFO. The write side can commit or
// drop a packet in progress; the read side can commit or rewind and replay.
// Four wrap-bit pointers: wr_ptr (next write), cwr_ptr (end of committed
// data), rd_ptr (next read), crd_ptr (start of unreleased data).
// Valid/ready rule: a beat moves on a rising clk edge exactly when srdy and
// drdy are both high; c_drdy and p_srdy are pure functions of registered
// pointers, so neither depends on the other side's handshake that cycle.
module sd_fifo_bx #(
  parameter int width     = 8,
  parameter int depth     = 16,
  parameter int commit_wr = 1,
  parameter int commit_rd = 1,
  parameter int afull_thr = depth - 2,
  parameter int asz       = $clog2(depth)
) (
  input logic           clk,
  input logic           reset,
  sd_fifo_bx_if.slave   io
);

  localparam logic [asz:0] depth_p = (asz+1)'(depth);
  localparam logic [asz:0] afull_p = (asz+1)'(afull_thr);

  logic [width-1:0] mem [depth];

  logic [asz:0] wr_ptr, cwr_ptr, rd_ptr, crd_ptr;
  logic [asz:0] wr_ptr_nxt, cwr_ptr_nxt, rd_ptr_nxt, crd_ptr_nxt;
  logic [asz:0] c_usage_w, p_usage_w;
  logic         c_drdy_w, p_srdy_w;
  logic         wr_en, rd_en;

  // Space is only returned by a read commit, so fullness is measured
  // against crd_ptr; readability is measured against committed writes.
  assign c_usage_w = wr_ptr - crd_ptr;
  assign p_usage_w = cwr_ptr - rd_ptr;
  assign c_drdy_w  = (c_usage_w != depth_p);
  assign p_srdy_w  = (cwr_ptr != rd_ptr);
  assign wr_en     = io.c_srdy & c_drdy_w;
  assign rd_en     = p_srdy_w & io.p_drdy;

  assign io.c_drdy  = c_drdy_w;
  assign io.p_srdy  = p_srdy_w;
  assign io.c_usage = c_usage_w;
  assign io.p_usage = p_usage_w;
  assign io.c_afull = (c_usage_w >= afull_p);
  assign io.p_data  = mem[rd_ptr[asz-1:0]];

  // Write side next pointers: abort beats commit; non-transactional mode
  // keeps the committed pointer locked to the write pointer.
  always_comb begin
    wr_ptr_nxt  = wr_ptr + {{asz{1'b0}}, wr_en};
    cwr_ptr_nxt = cwr_ptr;
    if (commit_wr == 0) begin
      cwr_ptr_nxt = wr_ptr_nxt;
    end else if (io.c_abort) begin
      wr_ptr_nxt = cwr_ptr;
    end else if (io.c_commit) begin
      cwr_ptr_nxt = wr_ptr_nxt;
    end
  end

  // Read side next pointers: abort rewinds to the last read commit and
  // beats commit; non-transactional mode releases every delivered beat.
  always_comb begin
    rd_ptr_nxt  = rd_ptr + {{asz{1'b0}}, rd_en};
    crd_ptr_nxt = crd_ptr;
    if (commit_rd == 0) begin
      crd_ptr_nxt = rd_ptr_nxt;
    end else if (io.p_abort) begin
      rd_ptr_nxt = crd_ptr;
    end else if (io.p_commit) begin
      crd_ptr_nxt = rd_ptr_nxt;
    end
  end

  // Pointer registers; reset empties the FIFO and loses all contents.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      wr_ptr  <= '0;
      cwr_ptr <= '0;
      rd_ptr  <= '0;
      crd_ptr <= '0;
    end else begin
      wr_ptr  <= wr_ptr_nxt;
      cwr_ptr <= cwr_ptr_nxt;
      rd_ptr  <= rd_ptr_nxt;
      crd_ptr <= crd_ptr_nxt;
    end
  end

  // Storage write; a beat dropped by abort lands above cwr_ptr and is
  // simply overwritten later.
  always_ff @(posedge clk) begin
    if (wr_en) begin
      mem[wr_ptr[asz-1:0]] <= io.c_data;
    end
  end

endmodule

// File: tb/tb_sd_fifo_bx.sv
// tb_sd_fifo_bx: directed bench for sd_fifo_bx. One transactional instance
// (depth 32) and one non-transactional instance (depth 8) share clk/reset.
// A queue-based model of each FIFO's contents is compared every cycle.
module tb_sd_fifo_bx;
  localparam int W   = 16;
  localparam int DT  = 32;
  localparam int DN  = 8;
  localparam int THR = 30;

  // ---------------- clock / reset ----------------
  logic clk = 1'b0;
  logic reset = 1'b0;
  always #5 clk = ~clk;

  sd_fifo_bx_if #(.width(W), .depth(DT)) ift ();
  sd_fifo_bx_if #(.width(W), .depth(DN)) ifn ();

  sd_fifo_bx #(.width(W), .depth(DT), .commit_wr(1), .commit_rd(1), .afull_thr(THR))
    dut_t (.clk(clk), .reset(reset), .io(ift));
  sd_fifo_bx #(.width(W), .depth(DN), .commit_wr(0), .commit_rd(0))
    dut_n (.clk(clk), .reset(reset), .io(ifn));

  int n_checks = 0;
  int n_errors = 0;

  task automatic check(input string name, input int act, input int exp);
    n_checks++;
    if (act != exp) begin
      n_errors++;
      $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
    end
  endtask

  // ---------------- model: transactional FIFO ----------------
  // exp_q holds every entry still occupying space (oldest unreleased first).
  // n_cmt: how many of those are committed; n_read: how many committed
  // ones have been read speculatively.
  logic [W-1:0] exp_q[$];
  int n_cmt, n_read;
  bit m_wr, m_rd;

  always @(posedge clk or posedge reset) begin
    if (reset) begin
      exp_q.delete();
      n_cmt  = 0;
      n_read = 0;
    end else begin
      m_wr = ift.c_srdy && (exp_q.size() != DT);
      m_rd = ift.p_drdy && ((n_cmt - n_read) > 0);
      if (m_wr) exp_q.push_back(ift.c_data);
      if (ift.c_abort) begin
        while (exp_q.size() > n_cmt) void'(exp_q.pop_back());
      end else if (ift.c_commit) begin
        n_cmt = exp_q.size();
      end
      if (ift.p_abort) begin
        n_read = 0;
      end else begin
        n_read += int'(m_rd);
        if (ift.p_commit) begin
          repeat (n_read) void'(exp_q.pop_front());
          n_cmt -= n_read;
          n_read = 0;
        end
      end
    end
  end

  // ---------------- model: plain FIFO ----------------
  logic [W-1:0] exq_n[$];
  bit n_wr, n_rd;

  always @(posedge clk or posedge reset) begin
    if (reset) begin
      exq_n.delete();
    end else begin
      n_wr = ifn.c_srdy && (exq_n.size() != DN);
      n_rd = ifn.p_drdy && (exq_n.size() > 0);
      if (n_rd) void'(exq_n.pop_front());
      if (n_wr) exq_n.push_back(ifn.c_data);
    end
  end

  // ---------------- compare process ----------------
  always @(negedge clk) begin
    if (!reset) begin
      check("t_c_drdy",  int'(ift.c_drdy),  int'(exp_q.size() != DT));
      check("t_p_srdy",  int'(ift.p_srdy),  int'((n_cmt - n_read) > 0));
      check("t_c_usage", int'(ift.c_usage), exp_q.size());
      check("t_p_usage", int'(ift.p_usage), n_cmt - n_read);
      check("t_c_afull", int'(ift.c_afull), int'(exp_q.size() >= THR));
      if ((n_cmt - n_read) > 0) check("t_p_data", int'(ift.p_data), int'(exp_q[n_read]));
      check("t_ptr_order", int'(ift.p_usage <= ift.c_usage && int'(ift.c_usage) <= DT), 1);
      check("n_c_drdy",  int'(ifn.c_drdy),  int'(exq_n.size() != DN));
      check("n_p_srdy",  int'(ifn.p_srdy),  int'(exq_n.size() > 0));
      check("n_c_usage", int'(ifn.c_usage), exq_n.size());
      check("n_usage_eq", int'(ifn.p_usage), int'(ifn.c_usage));
      check("n_c_afull", int'(ifn.c_afull), int'(exq_n.size() >= DN - 2));
      if (exq_n.size() > 0) check("n_p_data", int'(ifn.p_data), int'(exq_n[0]));
    end
  end

  // ---------------- driver tasks ----------------
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic wr_t(input logic [W-1:0] d, input bit cmt, input bit abt);
    int n = 0;
    while (!ift.c_drdy && n < 200) begin
      tick();
      n++;
    end
    check("t_wr_wait", int'(ift.c_drdy), 1);
    ift.c_srdy = 1'b1; ift.c_data = d; ift.c_commit = cmt; ift.c_abort = abt;
    tick();
    ift.c_srdy = 1'b0; ift.c_commit = 1'b0; ift.c_abort = 1'b0;
  endtask

  task automatic rd_t(output logic [W-1:0] d, input bit cmt, input bit abt);
    int n = 0;
    while (!ift.p_srdy && n < 200) begin
      tick();
      n++;
    end
    check("t_rd_wait", int'(ift.p_srdy), 1);
    ift.p_drdy = 1'b1; ift.p_commit = cmt; ift.p_abort = abt;
    d = ift.p_data;
    tick();
    ift.p_drdy = 1'b0; ift.p_commit = 1'b0; ift.p_abort = 1'b0;
  endtask

  task automatic pulse_t(input bit cc, input bit ca, input bit pc, input bit pa);
    ift.c_commit = cc; ift.c_abort = ca; ift.p_commit = pc; ift.p_abort = pa;
    tick();
    ift.c_commit = 1'b0; ift.c_abort = 1'b0; ift.p_commit = 1'b0; ift.p_abort = 1'b0;
  endtask

  // ---------------- global time limit ----------------
  initial begin
    #2000000;
    n_errors++;
    $display("FAIL timeout: run did not complete");
    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

  // ---------------- directed sequence ----------------
  initial begin
    logic [W-1:0] d;
    logic [7:0]   pw, pr;
    int wseq, rseq, full_seen, k;
    bit w_x, r_x;

    ift.c_srdy = 0; ift.c_commit = 0; ift.c_abort = 0; ift.c_data = '0;
    ift.p_drdy = 0; ift.p_commit = 0; ift.p_abort = 0;
    ifn.c_srdy = 0; ifn.c_commit = 0; ifn.c_abort = 0; ifn.c_data = '0;
    ifn.p_drdy = 0; ifn.p_commit = 0; ifn.p_abort = 0;

    #2 reset = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    check("rst_c_drdy",  int'(ift.c_drdy), 1);
    check("rst_p_srdy",  int'(ift.p_srdy), 0);
    check("rst_c_usage", int'(ift.c_usage), 0);
    check("rst_p_usage", int'(ift.p_usage), 0);
    check("rst_c_afull", int'(ift.c_afull), 0);
    reset = 1'b0;
    tick();

    // 1: write abort of a 31-beat packet
    for (int i = 0; i < 31; i++) begin
      wr_t(W'(i), 1'b0, 1'b0);
      check("s1_p_srdy", int'(ift.p_srdy), 0);
    end
    check("s1_c_usage_pre", int'(ift.c_usage), 31);
    check("s1_c_afull_pre", int'(ift.c_afull), 1);
    check("s1_c_drdy_pre",  int'(ift.c_drdy), 1);
    pulse_t(1'b0, 1'b1, 1'b0, 1'b0);
    check("s1_c_usage", int'(ift.c_usage), 0);
    check("s1_c_drdy",  int'(ift.c_drdy), 1);
    check("s1_p_srdy",  int'(ift.p_srdy), 0);

    // 2: commit on the last beat of a 31-beat packet
    for (int i = 0; i < 30; i++) wr_t(W'(i), 1'b0, 1'b0);
    check("s2_p_srdy_pre", int'(ift.p_srdy), 0);
    wr_t(W'(30), 1'b1, 1'b0);
    check("s2_p_srdy",  int'(ift.p_srdy), 1);
    check("s2_p_usage", int'(ift.p_usage), 31);
    check("s2_c_afull", int'(ift.c_afull), 1);
    for (int i = 0; i < 31; i++) begin
      rd_t(d, i == 30, 1'b0);
      check("s2_data", int'(d), i);
    end
    check("s2_c_usage", int'(ift.c_usage), 0);

    // 3: fill, read everything speculatively, rewind
    for (int i = 0; i < 32; i++) wr_t(W'(100 + i), i == 31, 1'b0);
    for (int i = 0; i < 32; i++) begin
      rd_t(d, 1'b0, 1'b0);
      check("s3_data", int'(d), 100 + i);
    end
    check("s3_p_srdy",  int'(ift.p_srdy), 0);
    check("s3_c_drdy",  int'(ift.c_drdy), 0);
    check("s3_c_usage", int'(ift.c_usage), 32);
    pulse_t(1'b0, 1'b0, 1'b0, 1'b1);
    check("s3_p_srdy_rw",  int'(ift.p_srdy), 1);
    check("s3_p_usage_rw", int'(ift.p_usage), 32);
    check("s3_p_data_rw",  int'(ift.p_data), 100);

    // 4: partial read commit after the replay
    for (int i = 0; i < 10; i++) begin
      rd_t(d, i == 9, 1'b0);
      check("s4_data", int'(d), 100 + i);
    end
    check("s4_c_usage", int'(ift.c_usage), 22);
    check("s4_c_drdy",  int'(ift.c_drdy), 1);
    check("s4_c_afull", int'(ift.c_afull), 0);
    for (int i = 10; i < 32; i++) begin
      rd_t(d, i == 31, 1'b0);
      check("s4_drain", int'(d), 100 + i);
    end
    check("s4_c_usage_end", int'(ift.c_usage), 0);

    // 5: simultaneous commit+abort on each side
    for (int i = 0; i < 3; i++) wr_t(W'(200 + i), i == 2, 1'b0);
    for (int i = 3; i < 8; i++) wr_t(W'(200 + i), 1'b0, 1'b0);
    check("s5_p_usage_pre", int'(ift.p_usage), 3);
    check("s5_c_usage_pre", int'(ift.c_usage), 8);
    wr_t(W'(208), 1'b1, 1'b1);
    check("s5_p_usage", int'(ift.p_usage), 3);
    check("s5_c_usage", int'(ift.c_usage), 3);
    wr_t(W'(209), 1'b1, 1'b0);
    check("s5_p_usage_add", int'(ift.p_usage), 4);
    rd_t(d, 1'b0, 1'b0); check("s5_rd0", int'(d), 200);
    rd_t(d, 1'b0, 1'b0); check("s5_rd1", int'(d), 201);
    rd_t(d, 1'b1, 1'b1); check("s5_rd2", int'(d), 202);
    check("s5_p_usage_rw", int'(ift.p_usage), 4);
    check("s5_c_usage_rw", int'(ift.c_usage), 4);
    rd_t(d, 1'b0, 1'b0); check("s5_rp0", int'(d), 200);
    rd_t(d, 1'b0, 1'b0); check("s5_rp1", int'(d), 201);
    rd_t(d, 1'b0, 1'b0); check("s5_rp2", int'(d), 202);
    rd_t(d, 1'b1, 1'b0); check("s5_rp3", int'(d), 209);
    check("s5_c_usage_end", int'(ift.c_usage), 0);

    // asynchronous reset in the middle of a packet
    wr_t(W'(300), 1'b1, 1'b0);
    wr_t(W'(301), 1'b0, 1'b0);
    #2 reset = 1'b1;
    #1;
    check("ar_c_usage", int'(ift.c_usage), 0);
    check("ar_p_usage", int'(ift.p_usage), 0);
    check("ar_p_srdy",  int'(ift.p_srdy), 0);
    check("ar_c_drdy",  int'(ift.c_drdy), 1);
    @(posedge clk);
    #1 reset = 1'b0;
    tick();

    // 6: non-transactional instance, fixed srdy/drdy patterns, noisy commit/abort
    pw = 8'h5A;
    pr = 8'hA5;
    wseq = 0; rseq = 0; full_seen = 0; k = 0;
    while (rseq < 2000 && k < 20000) begin
      ifn.c_srdy   = (k < 10) ? 1'b1 : pw[k % 8];
      ifn.p_drdy   = (k < 10) ? 1'b0 : pr[(k / 8 + k) % 8];
      ifn.c_data   = W'(wseq);
      ifn.c_commit = 1'($urandom_range(0, 1));
      ifn.c_abort  = 1'($urandom_range(0, 1));
      ifn.p_commit = 1'($urandom_range(0, 1));
      ifn.p_abort  = 1'($urandom_range(0, 1));
      if (!ifn.c_drdy) full_seen++;
      w_x = ifn.c_srdy & ifn.c_drdy;
      r_x = ifn.p_srdy & ifn.p_drdy;
      if (r_x) check("n_seq", int'(ifn.p_data), rseq % 65536);
      tick();
      if (w_x) wseq++;
      if (r_x) rseq++;
      k++;
    end
    check("n_beats", rseq, 2000);
    check("n_full_seen", int'(full_seen > 0), 1);
    ifn.c_srdy = 0; ifn.p_drdy = 1;
    ifn.c_commit = 0; ifn.c_abort = 0; ifn.p_commit = 0; ifn.p_abort = 0;
    k = 0;
    while (ifn.p_srdy && k < 100) begin
      tick();
      k++;
    end
    ifn.p_drdy = 0;
    check("n_drained", int'(ifn.c_usage), 0);
    check("n_drained_p", int'(ifn.p_usage), 0);
    tick();

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule
